// File: rtl/camera_control_pkg.sv
// Shared camera types: Q4.12 fixed point, vec3, camera modes and the home pose.
package camera_control_pkg;

  localparam int FP_W    = 16;
  localparam int FP_FRAC = 12;

  typedef logic signed [FP_W-1:0] fp_t;

  localparam fp_t FP_ZERO        = '0;
  localparam fp_t FP_ONE         = fp_t'(1 << FP_FRAC);
  localparam fp_t FP_THREE_HALFS = fp_t'(3 << (FP_FRAC - 1));
  localparam fp_t FP_FOUR        = fp_t'(4 << FP_FRAC);

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  typedef enum logic [1:0] {CAM_XY, CAM_XZ, CAM_ROT, CAM_HOME} cam_mode_t;

  localparam vec3_t HOME_POS = '{x: FP_ZERO, y: FP_ONE, z: -FP_THREE_HALFS};

  // One guard bit keeps the sum from wrapping before it is clamped to +/-lim.
  function automatic fp_t sat_step(input fp_t a, input logic signed [FP_W:0] d, input fp_t lim);
    logic signed [FP_W:0] sum;
    logic signed [FP_W:0] hi;
    sum = (FP_W+1)'(a) + d;
    hi  = (FP_W+1)'(lim);
    if (sum > hi) return lim;
    if (sum < -hi) return -lim;
    return sum[FP_W-1:0];
  endfunction

endpackage

// File: rtl/camera_control_if.sv
// Board-side controls in, committed camera pose out; slave is the controller side.
interface camera_control_if
  import camera_control_pkg::*;
#(
  parameter int ANGLE_BITS = 8
);
  logic                         btnl;
  logic                         btnr;
  logic                         btnu;
  logic                         btnd;
  logic [15:0]                  sw;
  logic                         frame_done_in;
  vec3_t                        pos_out;
  logic [ANGLE_BITS-1:0]        yaw_out;
  logic signed [ANGLE_BITS-1:0] pitch_out;
  logic [2:0]                   fractal_sel_out;
  logic                         cam_changed_out;

  modport master (
    output btnl, btnr, btnu, btnd, sw, frame_done_in,
    input  pos_out, yaw_out, pitch_out, fractal_sel_out, cam_changed_out
  );

  modport slave (
    input  btnl, btnr, btnu, btnd, sw, frame_done_in,
    output pos_out, yaw_out, pitch_out, fractal_sel_out, cam_changed_out
  );
endinterface

// File: rtl/camera_control_btn_sync.sv
// Two-flop synchroniser for one asynchronous push button; cleared by reset.
module camera_control_btn_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/camera_control.sv
// Camera pose controller: buttons move a working pose at a switch-selected tick rate;
// the pose is copied to the outputs only on frame_done_in so a frame sees one consistent view.
module camera_control
  import camera_control_pkg::*;
#(
  parameter int TICK_SHIFT  = 16,
  parameter int STEP_LSB    = 1,
  parameter int POS_LIMIT   = int'(FP_FOUR),
  parameter int ANGLE_BITS  = 8,
  parameter int PITCH_LIMIT = 60
) (
  input logic             clk_in,
  input logic             rst_in,
  camera_control_if.slave cam
);
  localparam int CW = TICK_SHIFT + 3;
  localparam int AW = ANGLE_BITS + 1;
  localparam fp_t                  POS_LIM   = fp_t'(POS_LIMIT);
  localparam logic signed [FP_W:0] STEP      = (FP_W+1)'(STEP_LSB);
  localparam logic signed [AW-1:0] PITCH_MAX = AW'(PITCH_LIMIT);
  localparam logic signed [AW-1:0] PITCH_MIN = -PITCH_MAX;

  logic btn_l, btn_r, btn_u, btn_d;

  camera_control_btn_sync u_sync_l (.clk_in(clk_in), .rst_in(rst_in), .d_i(cam.btnl), .q_o(btn_l));
  camera_control_btn_sync u_sync_r (.clk_in(clk_in), .rst_in(rst_in), .d_i(cam.btnr), .q_o(btn_r));
  camera_control_btn_sync u_sync_u (.clk_in(clk_in), .rst_in(rst_in), .d_i(cam.btnu), .q_o(btn_u));
  camera_control_btn_sync u_sync_d (.clk_in(clk_in), .rst_in(rst_in), .d_i(cam.btnd), .q_o(btn_d));

  logic [3:0]    sw_q;
  logic [CW-1:0] cnt_q, cnt_d, period_m1;
  logic          sw_chg, tick;
  cam_mode_t     mode;

  // Any mode/speed edit restarts the tick period so the new rate applies from a clean start.
  assign mode      = cam_mode_t'(sw_q[1:0]);
  assign sw_chg    = (cam.sw[3:0] != sw_q);
  assign period_m1 = ((CW'(sw_q[3:2]) + CW'(1)) << TICK_SHIFT) - CW'(1);
  assign tick      = !sw_chg && (cnt_q == period_m1);
  assign cnt_d     = (sw_chg || tick) ? '0 : cnt_q + CW'(1);

  logic lr_pos, lr_neg, ud_pos, ud_neg;
  assign lr_pos = btn_r & ~btn_l;
  assign lr_neg = btn_l & ~btn_r;
  assign ud_pos = btn_u & ~btn_d;
  assign ud_neg = btn_d & ~btn_u;

  logic signed [FP_W:0] dh, dv;
  assign dh = lr_pos ? STEP : (lr_neg ? -STEP : '0);
  assign dv = ud_pos ? STEP : (ud_neg ? -STEP : '0);

  vec3_t                        pos_q, pos_d;
  logic [ANGLE_BITS-1:0]        yaw_q, yaw_d;
  logic signed [ANGLE_BITS-1:0] pitch_q, pitch_d;
  logic signed [AW-1:0]         pitch_sum;

  assign pitch_sum = AW'(pitch_q) + (ud_pos ? AW'(1) : (ud_neg ? -AW'(1) : '0));

  always_comb begin
    pos_d   = pos_q;
    yaw_d   = yaw_q;
    pitch_d = pitch_q;
    if (tick) begin
      case (mode)
        CAM_XY: begin
          pos_d.x = sat_step(pos_q.x, dh, POS_LIM);
          pos_d.y = sat_step(pos_q.y, dv, POS_LIM);
        end
        CAM_XZ: begin
          pos_d.x = sat_step(pos_q.x, dh, POS_LIM);
          pos_d.z = sat_step(pos_q.z, dv, POS_LIM);
        end
        CAM_ROT: begin
          if (lr_pos)      yaw_d = yaw_q + 1'b1;
          else if (lr_neg) yaw_d = yaw_q - 1'b1;
          if (pitch_sum > PITCH_MAX)      pitch_d = PITCH_MAX[ANGLE_BITS-1:0];
          else if (pitch_sum < PITCH_MIN) pitch_d = PITCH_MIN[ANGLE_BITS-1:0];
          else                            pitch_d = pitch_sum[ANGLE_BITS-1:0];
        end
        CAM_HOME: begin
          if (btn_l | btn_r | btn_u | btn_d) begin
            pos_d   = HOME_POS;
            yaw_d   = '0;
            pitch_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  vec3_t                        pos_o_q;
  logic [ANGLE_BITS-1:0]        yaw_o_q;
  logic signed [ANGLE_BITS-1:0] pitch_o_q;
  logic [2:0]                   frac_q;
  logic                         chg_q, differs;

  // Commit copies the pre-tick working pose, so a coincident tick lands in the next frame.
  assign differs = (pos_q != pos_o_q) || (yaw_q != yaw_o_q) || (pitch_q != pitch_o_q) ||
                   (cam.sw[15:13] != frac_q);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sw_q      <= '0;
      cnt_q     <= '0;
      pos_q     <= HOME_POS;
      yaw_q     <= '0;
      pitch_q   <= '0;
      pos_o_q   <= HOME_POS;
      yaw_o_q   <= '0;
      pitch_o_q <= '0;
      frac_q    <= '0;
      chg_q     <= 1'b0;
    end else begin
      sw_q    <= cam.sw[3:0];
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      yaw_q   <= yaw_d;
      pitch_q <= pitch_d;
      chg_q   <= cam.frame_done_in && differs;
      if (cam.frame_done_in) begin
        pos_o_q   <= pos_q;
        yaw_o_q   <= yaw_q;
        pitch_o_q <= pitch_q;
        frac_q    <= cam.sw[15:13];
      end
    end
  end

  assign cam.pos_out         = pos_o_q;
  assign cam.yaw_out         = yaw_o_q;
  assign cam.pitch_out       = pitch_o_q;
  assign cam.fractal_sel_out = frac_q;
  assign cam.cam_changed_out = chg_q;
endmodule

// File: tb/tb_camera_control.sv
// Directed and randomized stimulus for camera_control, checked every cycle against an integer pose model.
module tb_camera_control;
  import camera_control_pkg::*;

  localparam int TS   = 2;
  localparam int STEP = 128;
  localparam int PL   = 16320;
  localparam int AB   = 8;
  localparam int PTL  = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  camera_control_if #(.ANGLE_BITS(AB)) cam ();

  camera_control #(
    .TICK_SHIFT(TS), .STEP_LSB(STEP), .POS_LIMIT(PL), .ANGLE_BITS(AB), .PITCH_LIMIT(PTL)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .cam   (cam)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int chg_pulses = 0;
  bit mon_en = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: integer pose, saturating/modular arithmetic straight from the rules.
  int m_x, m_y, m_z, m_yaw, m_pitch;
  int o_x, o_y, o_z, o_yaw, o_pitch, o_frac;
  bit o_chg;
  int m_cnt, m_sw;
  logic [3:0] s1, s2;

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : ((v < -lim) ? -lim : v);
  endfunction

  always @(posedge clk) begin : model
    int  per, hx, hv;
    bit  swc, tick, l, r, u, d;
    if (rst) begin
      m_x = 0; m_y = 4096; m_z = -6144; m_yaw = 0; m_pitch = 0;
      o_x = 0; o_y = 4096; o_z = -6144; o_yaw = 0; o_pitch = 0; o_frac = 0;
      o_chg = 0; m_cnt = 0; m_sw = 0; s1 = '0; s2 = '0;
    end else begin
      l = s2[3]; r = s2[2]; u = s2[1]; d = s2[0];
      swc  = (int'(cam.sw[3:0]) != m_sw);
      per  = (((m_sw >> 2) & 3) + 1) * (1 << TS);
      tick = !swc && (m_cnt == per - 1);
      m_cnt = (swc || tick) ? 0 : m_cnt + 1;
      o_chg = 0;
      if (cam.frame_done_in) begin
        o_chg = (o_x != m_x) || (o_y != m_y) || (o_z != m_z) || (o_yaw != m_yaw) ||
                (o_pitch != m_pitch) || (o_frac != int'(cam.sw[15:13]));
        o_x = m_x; o_y = m_y; o_z = m_z; o_yaw = m_yaw; o_pitch = m_pitch;
        o_frac = int'(cam.sw[15:13]);
      end
      hx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
      hv = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
      if (tick) begin
        case (m_sw & 3)
          0: begin m_x = clampi(m_x + hx*STEP, PL); m_y = clampi(m_y + hv*STEP, PL); end
          1: begin m_x = clampi(m_x + hx*STEP, PL); m_z = clampi(m_z + hv*STEP, PL); end
          2: begin m_yaw = (m_yaw + hx + 256) % 256; m_pitch = clampi(m_pitch + hv, PTL); end
          default: if (l || r || u || d) begin
            m_x = 0; m_y = 4096; m_z = -6144; m_yaw = 0; m_pitch = 0;
          end
        endcase
      end
      s2 = s1;
      s1 = {cam.btnl, cam.btnr, cam.btnu, cam.btnd};
      m_sw = int'(cam.sw[3:0]);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_x",     $signed(cam.pos_out.x), o_x);
      chk("out_y",     $signed(cam.pos_out.y), o_y);
      chk("out_z",     $signed(cam.pos_out.z), o_z);
      chk("out_yaw",   cam.yaw_out, o_yaw);
      chk("out_pitch", $signed(cam.pitch_out), o_pitch);
      chk("out_frac",  cam.fractal_sel_out, o_frac);
      chk("out_chg",   cam.cam_changed_out, o_chg);
      if (cam.cam_changed_out) chg_pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    cam.frame_done_in = 1'b1;
    cyc(1);
    cam.frame_done_in = 1'b0;
    cyc(1);
  endtask

  task automatic home_pose();
    cam.sw = 16'd3;
    cyc(3);
    cam.btnl = 1'b1;
    cyc(6);
    cam.btnl = 1'b0;
    cyc(3);
  endtask

  initial begin : stim
    int p0, pre, waited;
    bit found;
    cam.btnl = 0; cam.btnr = 0; cam.btnu = 0; cam.btnd = 0;
    cam.sw = '0; cam.frame_done_in = 0;
    @(posedge clk);
    mon_en = 1;
    cyc(3);
    rst = 0;

    // Idle after reset: home pose held, no change pulse
    cyc(20);
    chk("rst_x", $signed(cam.pos_out.x), 0);
    chk("rst_y", $signed(cam.pos_out.y), 4096);
    chk("rst_z", $signed(cam.pos_out.z), -6144);
    chk("rst_no_pulse", chg_pulses, 0);

    // XY, btnr held 40 cycles at speed 0
    cam.btnr = 1; cyc(40); cam.btnr = 0; cyc(4);
    p0 = chg_pulses;
    frame(); cyc(3);
    chk("xy_x_9or10", ($signed(cam.pos_out.x) == 9*STEP) || ($signed(cam.pos_out.x) == 10*STEP), 1);
    chk("xy_one_pulse", chg_pulses - p0, 1);

    // Home restores the reset pose
    cam.sw = 16'd3; cyc(3); cam.btnu = 1; cyc(6); cam.btnu = 0; cyc(3);
    frame();
    chk("home_x", $signed(cam.pos_out.x), 0);
    chk("home_y", $signed(cam.pos_out.y), 4096);

    // Rotation: yaw wraps both ways, pitch saturates both ways
    cam.sw = 16'd2; cyc(4);
    cam.btnl = 1; cyc(4); cam.btnl = 0; cyc(4); frame();
    chk("yaw_255", cam.yaw_out, 255);
    cam.btnr = 1; cyc(4); cam.btnr = 0; cyc(4); frame();
    chk("yaw_wrap0", cam.yaw_out, 0);
    cam.btnu = 1; cyc(70*4); cam.btnu = 0; cyc(4); frame();
    chk("pitch_pos_sat", $signed(cam.pitch_out), 60);
    cam.btnd = 1; cyc(130*4); cam.btnd = 0; cyc(4); frame();
    chk("pitch_neg_sat", $signed(cam.pitch_out), -60);

    // XZ: x walks up to the limit and clamps without wrapping
    home_pose();
    cam.sw = 16'd1; cyc(4);
    cam.btnr = 1; cyc(127*4); cam.btnr = 0; cyc(4); frame();
    chk("xz_near_lim", $signed(cam.pos_out.x), 127*STEP);
    cam.btnr = 1; cyc(3*4); cam.btnr = 0; cyc(4); frame();
    chk("xz_at_lim", $signed(cam.pos_out.x), PL);
    cam.btnr = 1; cyc(5*4); cam.btnr = 0; cyc(4); frame();
    chk("xz_no_wrap", $signed(cam.pos_out.x), PL);
    cam.btnl = 1; cam.btnr = 1; cyc(40); cam.btnl = 0; cam.btnr = 0; cyc(4); frame();
    chk("xz_lr_both", $signed(cam.pos_out.x), PL);

    // Tick coincident with frame_done: commit sees the pre-tick pose
    cam.sw = 16'd0; cyc(4);
    cam.btnl = 1;
    found = 0;
    waited = 0;
    while (!found && waited < 40) begin
      if (m_cnt == 3 && s2[3] && m_sw == 0) found = 1;
      else begin cyc(1); waited++; end
    end
    chk("coinc_wait", found, 1);
    pre = m_x;
    cam.frame_done_in = 1; cam.btnl = 0;
    cyc(1);
    cam.frame_done_in = 0;
    chk("coinc_pre", $signed(cam.pos_out.x), pre);
    cyc(6); frame();
    chk("coinc_next", $signed(cam.pos_out.x), pre - STEP);

    // Reset while moving, with a frame_done during reset
    cam.btnr = 1; cam.sw = 16'he000; cyc(10);
    rst = 1; cam.frame_done_in = 1;
    cyc(1);
    chk("midrst_x", $signed(cam.pos_out.x), 0);
    chk("midrst_pitch", $signed(cam.pitch_out), 0);
    chk("midrst_frac", cam.fractal_sel_out, 0);
    chk("midrst_chg", cam.cam_changed_out, 0);
    cam.frame_done_in = 0; cam.btnr = 0;
    cyc(2);
    rst = 0;
    cyc(5);

    // Random buttons, modes, speeds, fractal selects and frames
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        cam.btnl = 1'($urandom); cam.btnr = 1'($urandom);
        cam.btnu = 1'($urandom); cam.btnd = 1'($urandom);
      end
      if ($urandom_range(49) == 0) cam.sw = 16'($urandom);
      cam.frame_done_in = ($urandom_range(24) == 0);
      cyc(1);
    end
    cam.frame_done_in = 0;
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
